// File: rtl/flit_ingress_buffer_if.sv
// Crossbar-facing handshake of the flit ingress buffer: head flit, framing markers and valid/ready.
interface flit_ingress_buffer_if;
    logic [16:0] out_flit;
    logic        out_head;
    logic        out_tail;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_flit,
        output out_head,
        output out_tail,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_flit,
        input  out_head,
        input  out_tail,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/flit_ingress_buffer.sv
// Router ingress stage: frames the converter's flit stream into per-source packets and buffers
// them in a FIFO presented to the crossbar over valid/ready with head/tail markers.
module flit_ingress_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [16:0]            in_flit,
    flit_ingress_buffer_if.master  bus,
    output logic [AW:0]            level,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int unsigned PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    // Each entry is {head, tail, flit}.
    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic [PW-1:0] pos_q;
    logic [3:0]    pkt_src_q;
    logic          overflow_q, frame_err_q;

    logic in_valid, rsv_err, flit_ok, src_mismatch, pos_last;
    logic full, empty, rd_en, wr_en, drop;
    logic flit_head, flit_tail;

    always_comb begin
        in_valid     = in_flit[16];
        rsv_err      = in_valid && (in_flit[15:12] != 4'h0);
        flit_ok      = in_valid && !rsv_err;
        src_mismatch = flit_ok && (pos_q != '0) && (in_flit[11:8] != pkt_src_q);
        pos_last     = (pos_q == PW'(PKT_LEN - 1));
        flit_head    = (pos_q == '0) || src_mismatch;
        flit_tail    = pos_last && !src_mismatch;
        full         = (level_q == (AW + 1)'(DEPTH));
        empty        = (level_q == '0);
        rd_en        = !empty && bus.out_ready;
        // A same-edge read frees the slot, so a full FIFO still accepts.
        wr_en        = flit_ok && (!full || rd_en);
        drop         = flit_ok && full && !rd_en;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {flit_head, flit_tail, in_flit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pos_q       <= '0;
            pkt_src_q   <= 4'h0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // Framing follows the input stream even when the FIFO drops the flit.
            if (flit_ok) begin
                if (src_mismatch) begin
                    pkt_src_q <= in_flit[11:8];
                    pos_q     <= PW'(1);
                end else begin
                    if (pos_q == '0) begin
                        pkt_src_q <= in_flit[11:8];
                    end
                    pos_q <= pos_last ? '0 : pos_q + 1'b1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (rsv_err || src_mismatch) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_flit  = empty ? 17'h0 : mem_q[rd_ptr_q][16:0];
        bus.out_head  = !empty && mem_q[rd_ptr_q][18];
        bus.out_tail  = !empty && mem_q[rd_ptr_q][17];
        bus.out_valid = !empty;
        level         = level_q;
        overflow      = overflow_q;
        frame_err     = frame_err_q;
    end

endmodule

// File: tb/tb_flit_ingress_buffer.sv
// Self-checking bench for flit_ingress_buffer: directed test-plan steps followed by random
// traffic, every cycle compared against a queue-based packet-framing reference model.
module tb_flit_ingress_buffer;

    localparam int DEPTH   = 8;
    localparam int PKT_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [16:0] in_flit = 17'h0;
    logic [3:0]  level;
    logic        overflow, frame_err;

    flit_ingress_buffer_if bus ();

    flit_ingress_buffer #(
        .DEPTH   (DEPTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .bus       (bus),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {head, tail, flit}, packet position, current source, flags.
    logic [18:0] mq[$];
    int          m_pos;
    logic [3:0]  m_src;
    logic        m_ovf, m_ferr;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pos  = 0;
        m_src  = 4'h0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_step(input logic [16:0] f, input logic r);
        logic hd, tl;
        if (mq.size() != 0 && r) void'(mq.pop_front());
        if (f[16]) begin
            if (f[15:12] != 4'h0) begin
                m_ferr = 1'b1;
            end else begin
                if (m_pos != 0 && f[11:8] != m_src) begin
                    m_ferr = 1'b1;
                    hd = 1'b1;
                    tl = 1'b0;
                    m_src = f[11:8];
                    m_pos = 1;
                end else begin
                    hd = (m_pos == 0);
                    tl = (m_pos == PKT_LEN - 1);
                    if (m_pos == 0) m_src = f[11:8];
                    m_pos = (m_pos + 1) % PKT_LEN;
                end
                if (mq.size() < DEPTH) mq.push_back({hd, tl, f});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [18:0] e;
        e = (mq.size() != 0) ? mq[0] : 19'h0;
        chk("out_flit", 32'(bus.out_flit), 32'(e[16:0]));
        chk("out_head", 32'(bus.out_head), 32'(e[18]));
        chk("out_tail", 32'(bus.out_tail), 32'(e[17]));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic cycle(input logic [16:0] f, input logic r);
        in_flit       = f;
        bus.out_ready = r;
        model_step(f, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset is asserted together with a valid flit and ready to confirm reset priority.
    task automatic do_reset();
        rst           = 1'b1;
        in_flit       = 17'h1035A;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [16:0] f;
        logic        r;
        int          ready_pct;

        bus.out_ready = 1'b0;
        model_reset();
        do_reset();
        chk("reset_level_zero", 32'(level), 32'd0);

        // Single packet from source 3, drained one cycle behind the input.
        for (int i = 0; i < 4; i++) begin
            cycle(17'h10300 | 17'(8'h0A + i), 1'b1);
            chk("pkt_out_flit", 32'(bus.out_flit), 32'(17'h10300 | 17'(8'h0A + i)));
            chk("pkt_level_one", 32'(level), 32'd1);
        end
        cycle(17'h0, 1'b1);
        chk("pkt_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: two packets buffered, head held.
        for (int i = 0; i < 8; i++) cycle(17'h10300 | 17'(8'h0A + i), 1'b0);
        chk("bp_level_full", 32'(level), 32'd8);
        chk("bp_head_held", 32'(bus.out_flit), 32'h1030A);
        chk("bp_no_overflow", 32'(overflow), 32'd0);

        // Full with simultaneous read and write, then drain including the new flit.
        cycle(17'h10377, 1'b1);
        chk("rw_level_stays", 32'(level), 32'd8);
        chk("rw_no_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) cycle(17'h0, 1'b1);
        chk("rw_last_flit", 32'(bus.out_flit), 32'h0);

        // Overflow: nine flits with no reads.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(17'h10320 | 17'(i), 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        for (int i = 0; i < 9; i++) cycle(17'h0, 1'b1);

        // Source change mid-packet.
        do_reset();
        cycle(17'h10301, 1'b0);
        cycle(17'h10302, 1'b0);
        cycle(17'h10503, 1'b0);
        chk("src_frame_err", 32'(frame_err), 32'd1);
        cycle(17'h0, 1'b1);
        chk("src_frag_no_tail", 32'(bus.out_tail), 32'd0);
        cycle(17'h0, 1'b1);
        chk("src_new_head", 32'(bus.out_head), 32'd1);
        chk("src_new_flit", 32'(bus.out_flit), 32'h10503);

        // Reserved-bit violation, then reset clears everything.
        do_reset();
        cycle(17'h10311, 1'b0);
        cycle(17'h1F3AA, 1'b0);
        chk("rsv_level", 32'(level), 32'd1);
        chk("rsv_frame_err", 32'(frame_err), 32'd1);
        do_reset();
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic with varying read pressure and occasional resets.
        ready_pct = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) ready_pct = $urandom_range(10, 95);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                f = 17'($urandom);
                if ($urandom_range(0, 4) != 0) begin
                    f[16]    = 1'b1;
                    f[15:12] = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                    f[11:8]  = ($urandom_range(0, 15) == 0) ? 4'h5 : 4'h3;
                end else begin
                    f[16] = 1'b0;
                end
                r = ($urandom_range(0, 99) < ready_pct);
                cycle(f, r);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
